// File: rtl/arb_pkg.sv
// Shared sizes and FSM state type for the 32-way round-robin arbiter.
package arb_pkg;
   localparam int N_REQ = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/decoder5to32.sv
// Binary-to-one-hot decoder: 5-bit index to 32-bit one-hot vector.
module decoder5to32
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] i_sel,
   output logic [N_REQ-1:0] o_dec
);

   always_comb begin
      o_dec        = '0;
      o_dec[i_sel] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter32.sv
// 32-requester round-robin arbiter with release, request-drop and HOLD_MAX
// forced end; at least one IDLE cycle separates consecutive grants.
module rr_arbiter32
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             release_i,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N_REQ-1:0] grant_onehot,
   output logic             timeout
);

   localparam int                CNT_W     = $clog2(HOLD_MAX);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
   function automatic logic [IDX_W-1:0] f_pick(input logic [N_REQ-1:0] i_vec,
                                                input logic [IDX_W-1:0] i_ptr);
      logic [2*N_REQ-1:0] w_dbl;
      logic [N_REQ-1:0]   w_rot;
      logic [IDX_W-1:0]   w_off;
      logic               w_found;
      w_dbl   = {i_vec, i_vec};
      w_rot   = w_dbl[i_ptr +: N_REQ];
      w_off   = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_rot[i] && !w_found) begin
            w_off   = IDX_W'(i);
            w_found = 1'b1;
         end
      end
      return i_ptr + w_off;
   endfunction

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
   logic             r_grant_valid, w_valid_nxt;
   logic [IDX_W-1:0] r_grant_idx, w_idx_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_owner_req;
   logic [N_REQ-1:0] w_dec;

   assign w_owner_req = req[r_grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_hold_cnt    <= '0;
         r_grant_valid <= 1'b0;
         r_grant_idx   <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_grant_valid <= w_valid_nxt;
         r_grant_idx   <= w_idx_nxt;
         r_timeout     <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold_cnt;
      w_valid_nxt   = r_grant_valid;
      w_idx_nxt     = r_grant_idx;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_state_nxt = GRANT;
               w_valid_nxt = 1'b1;
               w_idx_nxt   = f_pick(req, r_ptr);
               w_hold_nxt  = '0;
            end
         end
         GRANT: begin
            // Only the hold limit can end a grant with release low and req still up.
            if (release_i || !w_owner_req || (r_hold_cnt == HOLD_LAST)) begin
               w_state_nxt   = IDLE;
               w_valid_nxt   = 1'b0;
               w_ptr_nxt     = r_grant_idx + 1'b1;
               w_timeout_nxt = !release_i && w_owner_req;
            end else begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   decoder5to32 u_dec (
      .i_sel (r_grant_idx),
      .o_dec (w_dec)
   );

   assign grant_onehot = w_dec & {N_REQ{r_grant_valid}};
   assign grant_valid  = r_grant_valid;
   assign grant_idx    = r_grant_idx;
   assign timeout      = r_timeout;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Self-checking bench for rr_arbiter32: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter32;

   localparam int HOLD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] req = '0;
   logic        release_i = 1'b0;
   logic        grant_valid;
   logic [4:0]  grant_idx;
   logic [31:0] grant_onehot;
   logic        timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: owner, search start, cycles held so far, timeout pulse.
   logic m_busy, m_to;
   int   m_idx, m_ptr, m_held;

   rr_arbiter32 #(.HOLD_MAX(HOLD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .release_i    (release_i),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_exp_oh();
      logic [31:0] v;
      v = '0;
      if (m_busy) v[m_idx] = 1'b1;
      return v;
   endfunction

   function automatic string got_s();
      return $sformatf("v=%b idx=%0d oh=%h to=%b", grant_valid, grant_idx, grant_onehot, timeout);
   endfunction

   function automatic string want_s();
      return $sformatf("v=%b idx=%0d oh=%h to=%b", m_busy, m_idx, f_exp_oh(), m_to);
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_to = 1'b0; m_idx = 0; m_ptr = 0; m_held = 0;
   endtask

   task automatic model_step(input logic [31:0] r, input logic rel);
      logic found;
      if (!m_busy) begin
         m_to  = 1'b0;
         found = 1'b0;
         for (int k = 0; k < 32; k++) begin
            if (!found && r[(m_ptr + k) % 32]) begin
               found  = 1'b1;
               m_busy = 1'b1;
               m_idx  = (m_ptr + k) % 32;
               m_held = 1;
            end
         end
      end else if (rel || !r[m_idx] || m_held == HOLD) begin
         m_to   = !rel && r[m_idx];
         m_busy = 1'b0;
         m_ptr  = (m_idx + 1) % 32;
      end else begin
         m_to   = 1'b0;
         m_held = m_held + 1;
      end
   endtask

   task automatic step(input logic [31:0] r, input logic rel);
      req       = r;
      release_i = rel;
      model_step(r, rel);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = '1; release_i = 1'b0; rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({grant_valid, grant_idx, grant_onehot, timeout} !== 39'd0)
         $display("FAIL reset_outputs: got %s, want all zero", got_s());
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      step('1, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd0 || grant_onehot !== 32'h1 || timeout !== 1'b0)
         $display("FAIL reset_first_grant: got %s, want v=1 idx=0 oh=00000001 to=0", got_s());
      else n_pass++;
      step('1, 1'b1);
      n_checks++;
      if ({grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to})
         $display("FAIL reset_release: got %s, want %s", got_s(), want_s());
      else n_pass++;
   endtask

   task automatic test_rotation();
      int owners[4] = '{0, 2, 4, 0};
      do_reset();
      for (int g = 0; g < 4; g++) begin
         step(32'h0000_0015, 1'b0);
         n_checks++;
         if (grant_valid !== 1'b1 || grant_idx !== owners[g][4:0] ||
             {grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to})
            $display("FAIL rotation_grant%0d: got %s, want owner %0d (%s)", g, got_s(), owners[g], want_s());
         else n_pass++;
         step(32'h0000_0015, 1'b1);
         n_checks++;
         if (grant_valid !== 1'b0 || grant_onehot !== 32'h0 || timeout !== 1'b0)
            $display("FAIL rotation_idle%0d: got %s, want v=0 oh=0 to=0", g, got_s());
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] pats[3] = '{32'h4000_0000, 32'h8000_0001, 32'h8000_0001};
      int          owners[3] = '{30, 31, 0};
      do_reset();
      for (int g = 0; g < 3; g++) begin
         step(pats[g], 1'b0);
         n_checks++;
         if (grant_valid !== 1'b1 || grant_idx !== owners[g][4:0] ||
             {grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to})
            $display("FAIL wrap_grant%0d: got %s, want owner %0d (%s)", g, got_s(), owners[g], want_s());
         else n_pass++;
         step(pats[g], 1'b1);
         n_checks++;
         if ({grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to})
            $display("FAIL wrap_idle%0d: got %s, want %s", g, got_s(), want_s());
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int held = 0;
      do_reset();
      for (int c = 0; c < HOLD; c++) begin
         step(32'h0000_0020, 1'b0);
         if (grant_valid === 1'b1 && grant_idx === 5'd5) held++;
         n_checks++;
         if ({grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to} ||
             (m_busy && grant_idx !== m_idx[4:0]))
            $display("FAIL timeout_hold_c%0d: got %s, want %s", c, got_s(), want_s());
         else n_pass++;
      end
      n_checks++;
      if (held != HOLD) $display("FAIL timeout_len: got %0d grant cycles, want %0d", held, HOLD);
      else n_pass++;
      step(32'h0000_0070, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b0 || timeout !== 1'b1 || grant_onehot !== 32'h0)
         $display("FAIL timeout_pulse: got %s, want v=0 oh=0 to=1", got_s());
      else n_pass++;
      step(32'h0000_0070, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd6 || timeout !== 1'b0 ||
          {grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to})
         $display("FAIL timeout_next_ptr: got %s, want v=1 idx=6 to=0", got_s());
      else n_pass++;
      step(32'h0000_0070, 1'b1);
   endtask

   task automatic test_drop();
      do_reset();
      step(32'h0000_0080, 1'b0);
      step(32'h0000_0088, 1'b0);
      step(32'h0000_0088, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd7 || grant_onehot !== 32'h80)
         $display("FAIL drop_owner: got %s, want v=1 idx=7 oh=00000080", got_s());
      else n_pass++;
      step(32'h0000_0008, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b0 || timeout !== 1'b0 || grant_onehot !== 32'h0)
         $display("FAIL drop_end: got %s, want v=0 oh=0 to=0", got_s());
      else n_pass++;
      step(32'h0000_0008, 1'b0);
      n_checks++;
      if ({grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to} || grant_idx !== m_idx[4:0])
         $display("FAIL drop_regrant: got %s, want %s", got_s(), want_s());
      else n_pass++;
   endtask

   task automatic test_reset_midgrant();
      step(32'h0000_0202, 1'b1);
      step(32'h0000_0200, 1'b0);
      step(32'h0000_0202, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({grant_valid, grant_idx, grant_onehot, timeout} !== 39'd0)
         $display("FAIL midgrant_reset: got %s, want all zero", got_s());
      else n_pass++;
      model_reset();
      #1;
      rst_n = 1'b1;
      step(32'h0000_0202, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 5'd1 || timeout !== 1'b0 || grant_onehot !== 32'h2)
         $display("FAIL midgrant_restart: got %s, want v=1 idx=1 oh=00000002 to=0", got_s());
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic        rel;
      do_reset();
      r = $urandom;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       r = '0;
               1:       r = $urandom & $urandom & $urandom;
               2:       r = r & ~(32'h1 << m_idx);
               default: r = $urandom;
            endcase
         end
         rel = ($urandom_range(0, 15) == 0);
         step(r, rel);
         n_checks++;
         if ({grant_valid, grant_onehot, timeout} !== {m_busy, f_exp_oh(), m_to} ||
             (m_busy && grant_idx !== m_idx[4:0]))
            $display("FAIL random_c%0d req=%h rel=%b: got %s, want %s", c, r, rel, got_s(), want_s());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rotation();
      test_wrap();
      test_timeout();
      test_drop();
      test_reset_midgrant();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter32.md
RR_ARBITER32 -- requirements
Module: rr_arbiter32

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, giving the maximum cycles one grant may be held; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 32 bits: one request line per requester, level-sensitive.
REQ-005 The block SHALL have port release_i, input, 1 bit: the current owner finishes its grant this cycle.
REQ-006 The block SHALL have port grant_valid, output, 1 bit: a grant is active.
REQ-007 The block SHALL have port grant_idx, output, 5 bits: binary index of the current owner.
REQ-008 The block SHALL have port grant_onehot, output, 32 bits: one-hot form of grant_idx, gated by grant_valid.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-ended by HOLD_MAX.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE with req nonzero, the block SHALL enter GRANT on the next edge, selecting the first set req bit at or above ptr and wrapping from 31 to 0.
REQ-012 Grant latency SHALL be exactly 1 cycle, from the IDLE cycle with a request to the cycle with grant_valid=1.
REQ-013 In IDLE with req equal to 0, the block SHALL remain in IDLE, with ptr unchanged.
REQ-014 In GRANT, grant_idx SHALL stay stable, and changes on other req bits SHALL be ignored.
REQ-015 GRANT SHALL end on the next edge when any of the following holds: release_i=1, req[grant_idx]=0, or hold_cnt=HOLD_MAX-1.
REQ-016 On GRANT end, the block SHALL go to IDLE and set ptr=grant_idx+1 modulo 32 (31 wraps to 0).
REQ-017 At least one IDLE cycle SHALL separate consecutive grants.
REQ-018 hold_cnt SHALL clear on entry to GRANT and increment each GRANT cycle; its width is clog2(HOLD_MAX).
REQ-019 timeout SHALL be 1 in the single cycle following a forced end, and only when release_i=0 and req[grant_idx]=1 at the ending edge.
REQ-020 When release_i and the HOLD_MAX limit coincide, release SHALL take priority, and timeout SHALL stay 0.
REQ-021 grant_onehot SHALL be all zeros whenever grant_valid=0.
REQ-022 grant_onehot SHALL have exactly one bit set, at position grant_idx, whenever grant_valid=1.
REQ-023 release_i SHALL be ignored in IDLE.
REQ-024 grant_valid, grant_idx and timeout SHALL be registered outputs; grant_onehot is combinational from registers only.

Reset
REQ-025 rst_n=0 SHALL asynchronously force the following values: state IDLE, ptr 0, hold_cnt 0, grant_valid 0, grant_idx 0, timeout 0, grant_onehot 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately, with no timeout pulse.
REQ-027 After rst_n rises, arbitration SHALL restart from ptr 0.

Structure
REQ-028 Package arb_pkg SHALL hold the following items: N_REQ=32, IDX_W=5, and the state enum {IDLE, GRANT}.
REQ-029 grant_onehot SHALL come from one instance of the existing decoder5to32 sub-module, with its output ANDed with grant_valid.
REQ-030 The priority search SHALL be a rotate-by-ptr followed by a find-first-set, in a local function.

Verification
REQ-031 Reset scenario: rst_n=0 with req=32'hFFFF_FFFF -> all outputs 0; after rst_n=1, one cycle later grant_idx=0 and grant_valid=1.
REQ-032 Rotation scenario: req=32'h0000_0015 held, with release_i pulsed each grant -> owners 0, 2, 4, 0, with one IDLE cycle between each.
REQ-033 Wrap scenario: ptr=31 after granting 30, req=32'h8000_0001 -> next owner 31, then 0.
REQ-034 Timeout scenario: HOLD_MAX=16, req[5] held, no release -> grant lasts 16 cycles, then timeout=1 for one cycle, then ptr=6.
REQ-035 Drop and reset scenario: owner 7 drops req[7] mid-grant -> IDLE next edge, timeout=0; rst_n pulsed low during GRANT -> grant_valid=0 immediately.
REQ-036 Onehot check, on every cycle of every test: grant_onehot==(grant_valid ? 1<<grant_idx : 0).
